// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised register file.
package rf_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 4;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_SWEEP = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_t;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry once (one per cycle) then pulses done for a cycle.
// Latency: clr_req accepted in RF_IDLE -> DEPTH busy cycles -> 1 done cycle; no backpressure.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              seq_idle,
  output logic              swp_we,
  output logic [ADDR_W-1:0] swp_idx
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) state_d = RF_SWEEP;
      end
      RF_SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_DONE: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_busy = (state_q == RF_SWEEP);
  assign clr_done = (state_q == RF_DONE);
  assign seq_idle = (state_q == RF_IDLE);
  assign swp_we   = clr_busy;
  assign swp_idx  = cnt_q;
endmodule

// File: rtl/rf_param.sv
// DATA_W x DEPTH register file, 1 write + 2 registered read ports, hardware clear sweep.
// Read latency 1 cycle; writes are dropped while a sweep runs. RF_BYPASS_EN enables same-edge write->read forwarding.
module rf_param
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic              RAE,
  input  logic [ADDR_W-1:0] RAA,
  input  logic              RBE,
  input  logic [ADDR_W-1:0] RBA,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_err,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  // One extra bit so addresses up to 2**ADDR_W-1 compare correctly when DEPTH is not a power of two.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              wr_err_q, wr_err_d;
  logic              seq_idle, swp_we;
  logic [ADDR_W-1:0] swp_idx;
  logic              wa_ok, raa_ok, rba_ok, wr_ok;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .seq_idle(seq_idle),
    .swp_we  (swp_we),
    .swp_idx (swp_idx)
  );

  always_comb begin
    wa_ok    = ({1'b0, WA} < DEPTH_L);
    raa_ok   = ({1'b0, RAA} < DEPTH_L);
    rba_ok   = ({1'b0, RBA} < DEPTH_L);
    wr_ok    = WE && seq_idle && wa_ok;
    wr_err_d = WE && seq_idle && !wa_ok;

    mem_d = mem_q;
    if (wr_ok)  mem_d[WA]      = data_in;
    if (swp_we) mem_d[swp_idx] = '0;

    // Reads see the pre-edge array; sweep writes are never forwarded.
    a_d = a_q;
    if (RAE) begin
      if (BYPASS && wr_ok && (RAA == WA)) a_d = data_in;
      else if (raa_ok)                    a_d = mem_q[RAA];
      else                                a_d = '0;
    end

    b_d = b_q;
    if (RBE) begin
      if (BYPASS && wr_ok && (RBA == WA)) b_d = data_in;
      else if (rba_ok)                    b_d = mem_q[RBA];
      else                                b_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      a_q      <= '0;
      b_q      <= '0;
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign wr_err = wr_err_q;
endmodule

// File: doc/rf_param.md
# rf_param

Parametrised successor to the GCD datapath register file: DATA_W-bit × DEPTH entries, one write port, two independently enabled read ports with registered (1-cycle) outputs. Adds out-of-range write detection, a hardware clear sequencer that zeroes the array one entry per cycle under a busy/done handshake, and optional write-to-read forwarding. Sits between the GCD controller and the datapath ALU; A and B feed the subtractor/comparator directly.

## Interface
- DATA_W, 8, entry and port data width
- DEPTH, 4, number of entries (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  DATA_W  write data
- WE  input  1  write enable
- WA  input  ADDR_W  write address
- RAE  input  1  read port A enable
- RAA  input  ADDR_W  read port A address
- RBE  input  1  read port B enable
- RBA  input  ADDR_W  read port B address
- clr_req  input  1  start clear sweep (level sampled each cycle)
- clr_busy  output  1  sweep in progress
- clr_done  output  1  one-cycle pulse when sweep completes
- wr_err  output  1  one-cycle pulse: write attempted to WA ≥ DEPTH
- A  output  DATA_W  read port A data
- B  output  DATA_W  read port B data

## Operation
- Reset: every entry = 0, A = B = 0, clr_busy = clr_done = wr_err = 0, FSM in RF_IDLE, sweep counter = 0.
- Write: at edge with WE=1, WA<DEPTH, FSM=RF_IDLE → mem[WA] ← data_in. WE=1 with WA≥DEPTH → no write, wr_err=1 next cycle. WE ignored (no write, no wr_err) while FSM≠RF_IDLE.
- Read: at edge with RAE=1 → A ← mem[RAA]; RAE=0 → A holds. RAA≥DEPTH → A ← 0. Port B identical with RBE/RBA. Both ports may read the same address in the same cycle.
- Clear FSM: RF_IDLE --clr_req--> RF_SWEEP; RF_SWEEP writes 0 to mem[cnt], cnt increments; on cnt=DEPTH-1 → RF_DONE; RF_DONE → RF_IDLE unconditionally, cnt ← 0.
- clr_busy = (state==RF_SWEEP); clr_done = (state==RF_DONE). clr_req ignored outside RF_IDLE; held high after done → new sweep starts from RF_IDLE on following edge.
- Reads remain live during sweep; they return stored value at that edge (entries already cleared read 0). No forwarding from sweep writes.
- Reset asserted mid-sweep: abort immediately, array fully zero, FSM RF_IDLE, no clr_done pulse.

## Timing
- Read latency 1 cycle: address/enable at edge N → data valid after edge N, held until next enabled read.
- Write visible to a read issued at a later edge; same-edge read/write collision governed by RF_BYPASS_EN.
- Sweep: clr_busy high exactly DEPTH cycles, clr_done high 1 cycle, then WE accepted again; total DEPTH+1 cycles from accepted clr_req to first accepted write.
- wr_err registered: pulses in cycle after offending edge.

## Configuration
- RF_BYPASS_EN defined: if WE write accepted and RAA==WA at same edge with RAE=1, A ← data_in (likewise B/RBA/RBE). Not applied to sweep writes or rejected writes.
- RF_BYPASS_EN undefined: same-edge collision returns old entry value; new value readable from next enabled read.

## Structure
- Package rf_pkg: rf_state_t enum {RF_IDLE, RF_SWEEP, RF_DONE}; default DATA_W/DEPTH constants.
- Sub-module rf_clear_seq: FSM + sweep counter; outputs clr_busy, clr_done, sweep write enable and index. Array, write decode and read muxes remain in rf_param.

## Test plan
- Reset then RAE=RBE=1, RAA=0, RBA=3 → A=B=0; clr_busy/clr_done/wr_err=0.
- Write 0x2A→1, 0x15→2; next edge RAA=1, RBA=2 → A=0x2A, B=0x15 one cycle later; RAE=0 with changing RAA → A holds 0x2A.
- Same-edge WE=1, WA=3, data_in=0x77, RAA=3 (entry was 0x10) → A=0x77 with RF_BYPASS_EN, A=0x10 without.
- DEPTH=5: WE=1, WA=6, data_in=0xFF → wr_err pulse 1 cycle, no entry changes; RAA=6 → A=0.
- Fill all entries with 0xAA, pulse clr_req → clr_busy 4 cycles (DEPTH=4), clr_done 1 cycle; WE during sweep ignored; all entries read 0 afterwards.
- Assert reset in 2nd sweep cycle → immediate all-zero state, clr_busy=0, no clr_done; write after deassert accepted.
